// File: rtl/conv_pkg.sv
// ============================================================================
// Module      : conv_pkg
// Description : Shared types, constants and address-fault check for the
//               convolution accelerator memory-side blocks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package conv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } resp_state_t;

    localparam logic [31:0] c_ERR_DATA = 32'hDEAD_BEEF;

    // A request faults when misaligned, below the window, or beyond its end.
    function automatic logic addr_fault(
        input logic [31:0] addr,
        input logic [31:0] base,
        input logic [31:0] depth
    );
        logic [31:0] w_off;
        w_off = addr - base;
        return (addr[1:0] != 2'b00) || (addr < base) || ((w_off >> 2) >= depth);
    endfunction

endpackage

`default_nettype wire

// File: rtl/conv_sram.sv
// ============================================================================
// Module      : conv_sram
// Description : 1R1W DEPTH x 32 scratchpad, registered read, read-before-write.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_sram #(
    parameter int unsigned DEPTH = 4096,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rd_en_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [31:0]   rd_data_o,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [31:0]   wr_data_i
);

    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rd_data;

    // Both updates are non-blocking, so a colliding read sees the old word.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            r_mem[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            r_rd_data <= r_mem[rd_addr_i];
        end
    end

    assign rd_data_o = r_rd_data;

endmodule

`default_nettype wire

// File: rtl/conv_mem_responder.sv
// ============================================================================
// Module      : conv_mem_responder
// Description : Answers held mem_rd requests with one word per mem_ack pulse
//               from a host-preloaded scratchpad; faults are flagged, not stalled.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_mem_responder
    import conv_pkg::*;
#(
    parameter int unsigned DEPTH        = 4096,
    parameter logic [31:0] BASE_ADDR    = 32'h8000_0000,
    parameter int unsigned READ_LATENCY = 1,
    parameter logic [31:0] ERR_DATA     = c_ERR_DATA
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     mem_rd_i,
    input  logic [31:0]              mem_addr_i,
    output logic                     mem_ack_o,
    output logic [31:0]              mem_data_o,
    input  logic                     wr_en_i,
    input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
    input  logic [31:0]              wr_data_i,
    output logic                     err_o,
    input  logic                     err_clr_i,
    output logic [31:0]              ack_count_o
);

    localparam int unsigned c_AW        = $clog2(DEPTH);
    localparam logic [3:0]  c_WAIT_INIT = (READ_LATENCY > 1) ? 4'(READ_LATENCY - 2) : 4'd0;

    generate
        if ((READ_LATENCY < 1) || (READ_LATENCY > 15) || ((1 << c_AW) != DEPTH)) begin : g_param_check
            $error("conv_mem_responder: illegal DEPTH or READ_LATENCY");
        end
    endgenerate

    resp_state_t       r_state;
    resp_state_t       w_state_nxt;
    logic [3:0]        r_cnt;
    logic              r_fault;
    logic              r_viol;
    logic              r_err;
    logic [31:0]       r_ack_count;
    logic              w_capture;
    logic              w_resp;
    logic [31:0]       w_offset;
    logic [c_AW-1:0]   w_rd_idx;
    logic [31:0]       w_rd_data;

    assign w_capture = (r_state == IDLE) && mem_rd_i;
    assign w_resp    = (r_state == RESP);
    assign w_offset  = mem_addr_i - BASE_ADDR;
    assign w_rd_idx  = c_AW'(w_offset >> 2);

    conv_sram #(
        .DEPTH (DEPTH),
        .AW    (c_AW)
    ) u_sram (
        .clk_i     (clk_i),
        .rd_en_i   (w_capture),
        .rd_addr_i (w_rd_idx),
        .rd_data_o (w_rd_data),
        .wr_en_i   (wr_en_i),
        .wr_addr_i (wr_addr_i),
        .wr_data_i (wr_data_i)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        mem_ack_o   = 1'b0;
        mem_data_o  = 32'd0;
        case (r_state)
            IDLE: begin
                if (mem_rd_i) begin
                    w_state_nxt = (READ_LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                w_state_nxt = IDLE;
                mem_ack_o   = 1'b1;
                mem_data_o  = r_fault ? ERR_DATA : w_rd_data;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // A drop of mem_rd_i while waiting is remembered and reported at the ack.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt       <= 4'd0;
            r_fault     <= 1'b0;
            r_viol      <= 1'b0;
            r_err       <= 1'b0;
            r_ack_count <= 32'd0;
        end else begin
            if (w_capture) begin
                r_cnt   <= c_WAIT_INIT;
                r_fault <= addr_fault(mem_addr_i, BASE_ADDR, 32'(DEPTH));
                r_viol  <= 1'b0;
            end else if (r_state == WAIT) begin
                if (r_cnt != 4'd0) begin
                    r_cnt <= r_cnt - 4'd1;
                end
                if (!mem_rd_i) begin
                    r_viol <= 1'b1;
                end
            end
            if (w_resp) begin
                r_ack_count <= r_ack_count + 32'd1;
            end
            if (w_resp && (r_fault || r_viol)) begin
                r_err <= 1'b1;
            end else if (err_clr_i) begin
                r_err <= 1'b0;
            end
        end
    end

    assign err_o       = r_err;
    assign ack_count_o = r_ack_count;

endmodule

`default_nettype wire

// File: tb/tb_conv_mem_responder.sv
// ============================================================================
// Module      : tb_conv_mem_responder
// Description : Self-checking bench: latency-1 and latency-4 responders driven
//               from a vector table, corner sequences and random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_conv_mem_responder;

    localparam logic [31:0] c_BASE = 32'h8000_0000;
    localparam logic [31:0] c_ERR  = 32'hDEAD_BEEF;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       mem_rd;
    logic [1:0][31:0] mem_addr;
    logic [1:0]       ack;
    logic [1:0][31:0] rdata;
    logic [1:0]       err;
    logic [1:0][31:0] cnt;
    logic             wr_en;
    logic [11:0]      wr_addr;
    logic [31:0]      wr_data;
    logic             err_clr;

    int n_err;
    int n_chk;
    int lat [2] = '{1, 4};
    int mdl_cnt [2];
    bit mdl_err [2];
    logic [31:0] shadow [4096];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] exp_data;
        bit          fault;
        bit          keep;
    } vec_t;
    vec_t vec [16];

    always #5 clk = ~clk;

    conv_mem_responder u_dut_l1 (
        .clk_i (clk), .rst_ni (rst_n), .mem_rd_i (mem_rd[0]), .mem_addr_i (mem_addr[0]),
        .mem_ack_o (ack[0]), .mem_data_o (rdata[0]), .wr_en_i (wr_en), .wr_addr_i (wr_addr),
        .wr_data_i (wr_data), .err_o (err[0]), .err_clr_i (err_clr), .ack_count_o (cnt[0])
    );

    conv_mem_responder #(.READ_LATENCY(4)) u_dut_l4 (
        .clk_i (clk), .rst_ni (rst_n), .mem_rd_i (mem_rd[1]), .mem_addr_i (mem_addr[1]),
        .mem_ack_o (ack[1]), .mem_data_o (rdata[1]), .wr_en_i (wr_en), .wr_addr_i (wr_addr),
        .wr_data_i (wr_data), .err_o (err[1]), .err_clr_i (err_clr), .ack_count_o (cnt[1])
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit mdl_fault(input logic [31:0] a);
        longint unsigned la;
        la = a;
        return (a % 4 != 0) || (la < 64'h8000_0000) || (la >= 64'h8000_0000 + 4096 * 4);
    endfunction

    function automatic logic [31:0] mdl_data(input logic [31:0] a);
        if (mdl_fault(a)) return c_ERR;
        return shadow[(a - c_BASE) / 4];
    endfunction

    task automatic host_write(input int idx, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = 12'(idx); wr_data = d;
        tick();
        wr_en = 1'b0;
        shadow[idx] = d;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        mdl_err[0] = 1'b0;
        mdl_err[1] = 1'b0;
    endtask

    // Issue one request and wait (bounded) for its ack; with keep the request
    // stays asserted so the caller can present the next address immediately.
    task automatic do_read(input int s, input logic [31:0] a, input logic [31:0] ed,
                           input bit f, input int exp_ticks, input bit keep);
        int n;
        mem_rd[s] = 1'b1;
        mem_addr[s] = a;
        n = 0;
        do begin
            tick();
            n++;
        end while (!ack[s] && n < 40);
        chk("ack_latency", 32'(n), 32'(exp_ticks));
        chk("ack_data", rdata[s], ed);
        if (ack[s]) begin
            mdl_cnt[s]++;
            if (f) mdl_err[s] = 1'b1;
        end
        if (!keep) begin
            mem_rd[s] = 1'b0;
            tick();
            chk("ack_idle", {31'd0, ack[s]}, 32'd0);
            chk("data_idle", rdata[s], 32'd0);
            chk("err_flag", {31'd0, err[s]}, {31'd0, mdl_err[s]});
            chk("ack_count", cnt[s], 32'(mdl_cnt[s]));
        end
    endtask

    initial begin
        int n;
        n_err = 0; n_chk = 0;
        mdl_cnt = '{0, 0}; mdl_err = '{1'b0, 1'b0};
        rst_n = 1'b0; mem_rd = '0; mem_addr = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; err_clr = 1'b0;
        repeat (2) tick();
        for (int s = 0; s < 2; s++) begin
            chk("rst_ack", {31'd0, ack[s]}, 32'd0);
            chk("rst_data", rdata[s], 32'd0);
            chk("rst_err", {31'd0, err[s]}, 32'd0);
            chk("rst_count", cnt[s], 32'd0);
        end
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 32; i++) host_write(i, (i < 9) ? 32'(i + 1) : $urandom);
        host_write(4095, 32'hA5A5_0FFF);

        for (int i = 0; i < 9; i++) vec[i] = '{c_BASE + 32'(4 * i), 32'(i + 1), 1'b0, (i < 8)};
        vec[9]  = '{32'h8000_0002, c_ERR, 1'b1, 1'b0};
        vec[10] = '{32'h8000_4000, c_ERR, 1'b1, 1'b0};
        vec[11] = '{32'h7FFF_FFFC, c_ERR, 1'b1, 1'b0};
        vec[12] = '{32'h8000_3FFC, 32'hA5A5_0FFF, 1'b0, 1'b0};
        vec[13] = '{32'h8000_0008, 32'd3, 1'b0, 1'b1};
        vec[14] = '{32'h8000_0008, 32'd3, 1'b0, 1'b1};
        vec[15] = '{32'h8000_0008, 32'd3, 1'b0, 1'b0};
        for (int i = 0; i < 16; i++) begin
            do_read(0, vec[i].addr, vec[i].exp_data, vec[i].fault,
                    (i > 0 && vec[i-1].keep) ? 2 : 1, vec[i].keep);
        end

        pulse_clr();
        chk("err_cleared", {31'd0, err[0]}, 32'd0);

        // Clear request in the same cycle as a faulting ack: the fault wins.
        mem_rd[0] = 1'b1; mem_addr[0] = c_BASE + 32'd1;
        tick();
        chk("setwins_ack", {31'd0, ack[0]}, 32'd1);
        chk("setwins_data", rdata[0], c_ERR);
        err_clr = 1'b1; mem_rd[0] = 1'b0;
        tick();
        err_clr = 1'b0;
        mdl_cnt[0]++; mdl_err[0] = 1'b1;
        chk("setwins_err", {31'd0, err[0]}, 32'd1);
        pulse_clr();
        chk("err_cleared2", {31'd0, err[0]}, 32'd0);

        // Host write and read capture of word 5 on the same edge.
        host_write(5, 32'h11);
        mem_rd[0] = 1'b1; mem_addr[0] = c_BASE + 32'd20;
        wr_en = 1'b1; wr_addr = 12'd5; wr_data = 32'h55;
        tick();
        wr_en = 1'b0; shadow[5] = 32'h55;
        chk("collide_ack", {31'd0, ack[0]}, 32'd1);
        chk("collide_data", rdata[0], 32'h11);
        mem_rd[0] = 1'b0;
        tick();
        mdl_cnt[0]++;
        do_read(0, c_BASE + 32'd20, 32'h55, 1'b0, 1, 1'b0);

        do_read(1, c_BASE + 32'h10, shadow[4], 1'b0, 4, 1'b0);

        // mem_rd dropped during WAIT: still acks, and flags the violation.
        mem_rd[1] = 1'b1; mem_addr[1] = c_BASE;
        tick();
        mem_rd[1] = 1'b0;
        n = 1;
        while (!ack[1] && n < 40) begin
            tick();
            n++;
        end
        chk("viol_latency", 32'(n), 32'd4);
        chk("viol_data", rdata[1], shadow[0]);
        tick();
        mdl_cnt[1]++; mdl_err[1] = 1'b1;
        chk("viol_err", {31'd0, err[1]}, 32'd1);
        chk("viol_count", cnt[1], 32'(mdl_cnt[1]));
        pulse_clr();

        // Reset two cycles after capture aborts the transaction.
        mem_rd[1] = 1'b1; mem_addr[1] = c_BASE + 32'h10;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        mdl_cnt = '{0, 0}; mdl_err = '{1'b0, 1'b0};
        chk("midrst_ack", {31'd0, ack[1]}, 32'd0);
        chk("midrst_data", rdata[1], 32'd0);
        chk("midrst_err", {31'd0, err[1]}, 32'd0);
        chk("midrst_count", cnt[1], 32'd0);
        tick();
        tick();
        chk("midrst_noack", {31'd0, ack[1]}, 32'd0);
        rst_n = 1'b1;
        do_read(1, c_BASE + 32'h10, shadow[4], 1'b0, 4, 1'b0);

        for (int it = 0; it < 60; it++) begin
            int s, k, w;
            logic [31:0] a;
            k = $urandom_range(0, 11);
            w = $urandom_range(0, 31);
            if (k == 10) begin
                host_write(w, $urandom);
            end else if (k == 11) begin
                pulse_clr();
                chk("rand_clr0", {31'd0, err[0]}, 32'd0);
            end else begin
                s = $urandom_range(0, 1);
                if (k < 7)       a = c_BASE + 32'(4 * w);
                else if (k == 7) a = c_BASE + 32'(4 * w) + 32'($urandom_range(1, 3));
                else if (k == 8) a = c_BASE + 32'(4 * 4096) + 32'(4 * w);
                else             a = c_BASE - 32'd4 - 32'(4 * w);
                do_read(s, a, mdl_data(a), mdl_fault(a), lat[s], 1'b0);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/conv_mem_responder.md
# conv_mem_responder

Memory-side responder for the convolution accelerator's LSU read interface. It answers the level-held `mem_rd`/`mem_addr` requests issued by the convolution unit during its kernel and input loads, returning one 32-bit word per `mem_ack` pulse from a local word-addressed scratchpad. A host-side write port preloads kernels and input tiles. Out-of-range or misaligned requests are flagged, never stalled.

## Interface
- `DEPTH`, 4096: scratchpad size in 32-bit words; must be a power of two.
- `BASE_ADDR`, 32'h8000_0000: byte address of word 0.
- `READ_LATENCY`, 1: cycles from request capture to `mem_ack_o`; must be 1 to 15.
- `ERR_DATA`, 32'hDEAD_BEEF: data returned for a faulting request.

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset; one clock; reset is asynchronous and active-low.
- `mem_rd_i`  in  1  read request, held high until acked.
- `mem_addr_i`  in  32  byte address, stable while `mem_rd_i` is high.
- `mem_ack_o`  out  1  one-cycle pulse; `mem_data_o` is valid in that cycle.
- `mem_data_o`  out  32  read data.
- `wr_en_i`  in  1  host preload write strobe.
- `wr_addr_i`  in  $clog2(DEPTH)  word index.
- `wr_data_i`  in  32  write data.
- `err_o`  out  1  sticky fault flag.
- `err_clr_i`  in  1  clears `err_o`.
- `ack_count_o`  out  32  count of acks since reset; wraps at 2^32.

## Operation
- FSM states: IDLE, WAIT, RESP.
  - IDLE with `mem_rd_i=1`: capture the address and compute the fault.
    - Fault when `mem_addr_i[1:0]!=0`, `mem_addr_i<BASE_ADDR`, or `(mem_addr_i-BASE_ADDR)>>2 >= DEPTH`.
    - On the same edge, read the array into the data register.
    - Go to RESP if `READ_LATENCY==1`; otherwise go to WAIT with the counter set to `READ_LATENCY-2`.
  - WAIT: decrement the counter. At 0, go to RESP.
  - RESP: `mem_ack_o=1`. `mem_data_o` is the captured word, or `ERR_DATA` on a fault. Set `err_o` on a fault. Increment `ack_count_o`. Go to IDLE.
- Each ack consumes exactly one request. A `mem_rd_i` still high in the IDLE cycle after RESP is a new request, even if the address is unchanged.
- Only one request is outstanding at a time. Address changes during WAIT or RESP are ignored.
- `mem_rd_i` dropping during WAIT is a protocol violation. The transaction still completes and acks, and `err_o` is set.
- Host writes take effect at the clock edge and are independent of the FSM.
- Same-edge host write and read capture to the same word: the read returns the old data (read-before-write).
- `err_clr_i` together with a new fault in RESP: set wins.
- `mem_data_o` is 0 whenever `mem_ack_o` is 0.

## Timing
- Reset values:
  - state = IDLE, counter = 0.
  - `mem_ack_o=0`, `mem_data_o=0`, `err_o=0`, `ack_count_o=0`.
  - Array contents are not reset.
- Reset asserted mid-transaction aborts it; no ack is produced. After release, a still-high `mem_rd_i` is treated as a fresh request.
- Latency: request seen in IDLE at cycle N leads to ack at cycle N+`READ_LATENCY`.
- Throughput is one word per `READ_LATENCY+1` cycles, i.e. 2 cycles per word at the default latency.

## Structure
- Package `conv_pkg` holds:
  - the `resp_state_t` enum (IDLE/WAIT/RESP);
  - the default `ERR_DATA` constant;
  - the address-fault check function, shared with future LSU-side blocks.
- Sub-module `conv_sram`: 1R1W array of `DEPTH`x32, synchronous registered read with read-before-write semantics. The responder instantiates one.

## Test plan
- Default latency: preload words 0..8 with 1..9, then hold `mem_rd_i` over addresses 0x8000_0000..0x8000_0020 stepping after each ack. Expect 9 acks, each 1 cycle after capture, data 1..9 in order, and `ack_count_o=9`.
- `READ_LATENCY=4`: a single request at 0x8000_0010 gives an ack exactly 4 cycles after capture with the preloaded value, and no ack before that.
- Fault: a request at 0x8000_0002 acks with 0xDEADBEEF and sets `err_o`. A request at 0x8000_4000 (DEPTH=4096) behaves the same. Pulsing `err_clr_i` clears `err_o`.
- Same-address hold: `mem_rd_i` stays high at one address for 3 acks. Expect 3 acks spaced 2 cycles apart, each returning the same data.
- Write collision: same-edge host write of 0x55 and read capture of word 5 (old value 0x11). The ack returns 0x11; a following read returns 0x55.
- Reset mid-WAIT (`READ_LATENCY=4`): pull `rst_ni` low 2 cycles after capture. No ack follows, and all outputs read 0. After release with `mem_rd_i` still high, an ack arrives 4 cycles later.
